// File: rtl/ws281x_pkg.sv
// Shared types and counter widths for the WS281x receive path.
package ws281x_pkg;
    localparam int HCNT_W = 8;
    localparam int LCNT_W = 16;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} ws281x_rx_state_t;
endpackage

// File: rtl/ws281x_decode_if.sv
// Decoded-byte output bundle of the WS281x receiver.
interface ws281x_decode_if;
    // byte_vld_o, frame_end_o and err_o are single-cycle valid strobes with no
    // ready: the consumer must take every pulse, byte_data_o holds between bytes.
    logic       byte_vld_o;
    logic [7:0] byte_data_o;
    logic       frame_end_o;
    logic       err_o;

    modport master (output byte_vld_o, byte_data_o, frame_end_o, err_o);
    modport slave  (input  byte_vld_o, byte_data_o, frame_end_o, err_o);
endinterface

// File: rtl/ws281x_sync.sv
// Two-flop synchronizer plus history flop for an asynchronous pin, with edge strobes.
module ws281x_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1, s2, s3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level_o = s2;
    assign rise_o  = s2 & ~s3;
    assign fall_o  = ~s2 & s3;
endmodule

// File: rtl/ws281x_decode.sv
// WS281x NRZ receiver: classifies high pulses by width, packs bits MSB-first,
// flags frame resets (long low) and protocol errors.
module ws281x_decode
    import ws281x_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  din_i,
    input  logic [HCNT_W-1:0]     thr_cnt_i,
    input  logic [HCNT_W-1:0]     max_cnt_i,
    input  logic [LCNT_W-1:0]     rst_cnt_i,
    ws281x_decode_if.master       out_if,
    output ws281x_rx_state_t      state_o
);
    logic level, rise, fall;

    ws281x_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (din_i),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    ws281x_rx_state_t  state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc, rst_lim;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        sh_q, sh_d, data_q, data_d;
    logic              vld_q, vld_d, fe_q, fe_d, err_q, err_d;
    logic              bit_now;

    assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + HCNT_W'(1);
    assign lcnt_inc = (lcnt_q == '1) ? lcnt_q : lcnt_q + LCNT_W'(1);
    assign rst_lim  = (rst_cnt_i == '0) ? LCNT_W'(1) : rst_cnt_i;
    assign bit_now  = (hcnt_q >= thr_cnt_i);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        lcnt_d    = lcnt_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        fe_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            SYNC: begin
                bit_idx_d = '0;
                if (lcnt_q == rst_lim) state_d = IDLE;
                else if (level)        lcnt_d  = '0;
                else                   lcnt_d  = lcnt_inc;
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = HCNT_W'(1);
                end
            end
            HIGH: begin
                // Overlong check wins over a coincident fall; hcnt saturation
                // means max_cnt_i = 255 can never trip it.
                if (hcnt_q > max_cnt_i) begin
                    err_d     = 1'b1;
                    bit_idx_d = '0;
                    lcnt_d    = '0;
                    state_d   = SYNC;
                end else if (fall) begin
                    sh_d      = {sh_q[6:0], bit_now};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        data_d = {sh_q[6:0], bit_now};
                        vld_d  = 1'b1;
                    end
                    lcnt_d  = LCNT_W'(1);
                    state_d = LOW;
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            LOW: begin
                if (lcnt_q == rst_lim) begin
                    fe_d    = 1'b1;
                    state_d = IDLE;
                    if (bit_idx_q != 3'd0) begin
                        err_d     = 1'b1;
                        bit_idx_d = '0;
                    end
                end else if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = HCNT_W'(1);
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SYNC;
            hcnt_q    <= '0;
            lcnt_q    <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            fe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            lcnt_q    <= lcnt_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            fe_q      <= fe_d;
            err_q     <= err_d;
        end
    end

    assign out_if.byte_vld_o  = vld_q;
    assign out_if.byte_data_o = data_q;
    assign out_if.frame_end_o = fe_q;
    assign out_if.err_o       = err_q;
    assign state_o            = state_q;
endmodule
